// File: rtl/alu_acc_seq.sv
// alu_acc_seq: LOAD/ADD/SUB/CLR accumulator front-end for the 4-bit AddSub4b adder.
// Latency: LOAD/CLR result 1 cycle after accept; ADD/SUB result SETTLE cycles after accept.
// Backpressure: o_cmd_ready low while an ADD/SUB waits on the adder. Define ALU_ACC_SAT_EN for saturating math.
module alu_acc_seq #(
  parameter int SETTLE = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [3:0] i_cmd_data,
  output logic [3:0] o_alu_a,
  output logic [3:0] o_alu_b,
  output logic       o_alu_ctrl,
  input  logic [3:0] i_alu_s,
  input  logic       i_alu_c0,
  output logic [3:0] o_acc,
  output logic       o_flag_c,
  output logic       o_flag_z,
  output logic       o_flag_v,
  output logic       o_res_valid
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // Counter value seen on the edge that captures the adder result.
  localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic       r_alu_ctrl;
  logic [3:0] r_acc;
  logic       r_flag_c;
  logic       r_flag_z;
  logic       r_flag_v;
  logic       r_res_valid;

  logic       w_accept;
  logic       w_done;
  logic       w_v;
  logic [3:0] w_result;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, ready and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        w_accept    = i_cmd_valid;
        if (i_cmd_valid && ((i_cmd_op == OP_ADD) || (i_cmd_op == OP_SUB))) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == LP_LAST) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Signed overflow of the adder result and the value written to the accumulator.
  always_comb begin
    w_v = 1'b0;
    if (r_alu_ctrl) begin
      w_v = (r_alu_a[3] != r_alu_b[3]) && (i_alu_s[3] != r_alu_a[3]);
    end else begin
      w_v = (r_alu_a[3] == r_alu_b[3]) && (i_alu_s[3] != r_alu_a[3]);
    end
`ifdef ALU_ACC_SAT_EN
    // Overflow direction follows the sign of the first operand.
    if (w_v) begin
      w_result = r_alu_a[3] ? 4'b1000 : 4'b0111;
    end else begin
      w_result = i_alu_s;
    end
`else
    w_result = i_alu_s;
`endif
  end

  // Operand, counter, accumulator and flag registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= 4'd0;
      r_alu_a     <= 4'd0;
      r_alu_b     <= 4'd0;
      r_alu_ctrl  <= 1'b0;
      r_acc       <= 4'd0;
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b1;
      r_flag_v    <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_accept) begin
        case (i_cmd_op)
          OP_LOAD: begin
            r_acc       <= i_cmd_data;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_flag_z    <= (i_cmd_data == 4'd0);
            r_res_valid <= 1'b1;
          end
          OP_CLR: begin
            r_acc       <= 4'd0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_flag_z    <= 1'b1;
            r_res_valid <= 1'b1;
          end
          default: begin
            // ADD or SUB: launch the operands into the adder and start settling.
            r_alu_a    <= r_acc;
            r_alu_b    <= i_cmd_data;
            r_alu_ctrl <= (i_cmd_op == OP_SUB);
            r_cnt      <= 4'd0;
          end
        endcase
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt + 4'd1;
        if (w_done) begin
          r_acc       <= w_result;
          r_flag_c    <= i_alu_c0;
          r_flag_v    <= w_v;
          r_flag_z    <= (w_result == 4'd0);
          r_res_valid <= 1'b1;
        end
      end
    end
  end

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_ctrl  = r_alu_ctrl;
  assign o_acc       = r_acc;
  assign o_flag_c    = r_flag_c;
  assign o_flag_z    = r_flag_z;
  assign o_flag_v    = r_flag_v;
  assign o_res_valid = r_res_valid;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Self-checking bench for alu_acc_seq: unit 0 with SETTLE=1, unit 1 with SETTLE=4.
// Each unit drives a behavioural AddSub4b; a scoreboard holds expected acc/flags.
// Expected results are pushed at command issue and compared on each res_valid pulse.
module tb_alu_acc_seq;

  typedef struct packed {
    logic [3:0] acc;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst [2];
  logic       cv [2];
  logic       rdy [2];
  logic [1:0] op [2];
  logic [3:0] dat [2];
  logic [3:0] aa [2];
  logic [3:0] bb [2];
  logic       ctl [2];
  logic [3:0] ss [2];
  logic       c0 [2];
  logic [3:0] acc [2];
  logic       fc [2];
  logic       fz [2];
  logic       fv [2];
  logic       rv [2];

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [3:0] m_acc [2];
  logic [3:0] m_a [2];
  logic [3:0] m_b [2];
  logic       m_c [2];
  logic       last_rv;

  always #5 clk = ~clk;

  alu_acc_seq #(.SETTLE(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_cmd_valid(cv[0]), .o_cmd_ready(rdy[0]),
    .i_cmd_op(op[0]), .i_cmd_data(dat[0]), .o_alu_a(aa[0]), .o_alu_b(bb[0]),
    .o_alu_ctrl(ctl[0]), .i_alu_s(ss[0]), .i_alu_c0(c0[0]), .o_acc(acc[0]),
    .o_flag_c(fc[0]), .o_flag_z(fz[0]), .o_flag_v(fv[0]), .o_res_valid(rv[0])
  );

  alu_acc_seq #(.SETTLE(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_cmd_valid(cv[1]), .o_cmd_ready(rdy[1]),
    .i_cmd_op(op[1]), .i_cmd_data(dat[1]), .o_alu_a(aa[1]), .o_alu_b(bb[1]),
    .o_alu_ctrl(ctl[1]), .i_alu_s(ss[1]), .i_alu_c0(c0[1]), .o_acc(acc[1]),
    .o_flag_c(fc[1]), .o_flag_z(fz[1]), .o_flag_v(fv[1]), .o_res_valid(rv[1])
  );

  // Behavioural AddSub4b: subtract is A + ~B + 1, C0 is the carry out.
  assign {c0[0], ss[0]} = ctl[0] ? ({1'b0, aa[0]} + {1'b0, ~bb[0]} + 5'd1) : ({1'b0, aa[0]} + {1'b0, bb[0]});
  assign {c0[1], ss[1]} = ctl[1] ? ({1'b0, aa[1]} + {1'b0, ~bb[1]} + 5'd1) : ({1'b0, aa[1]} + {1'b0, bb[1]});

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model of one command, computed with signed/unsigned integers.
  function automatic exp_t model(input logic [3:0] a, input logic [1:0] o, input logic [3:0] d);
    exp_t e;
    int   sa, sd, r, u;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sd = d[3] ? int'(d) - 16 : int'(d);
    e  = '0;
    r  = 0;
    case (o)
      2'b00: e.acc = d;
      2'b11: e.acc = 4'd0;
      2'b01: begin
        u     = int'(a) + int'(d);
        e.c   = (u > 15);
        e.acc = 4'(u % 16);
        r     = sa + sd;
        e.v   = (r > 7) || (r < -8);
      end
      default: begin
        u     = int'(a) - int'(d) + 16;
        e.c   = (a >= d);
        e.acc = 4'(u % 16);
        r     = sa - sd;
        e.v   = (r > 7) || (r < -8);
      end
    endcase
`ifdef ALU_ACC_SAT_EN
    if (e.v) e.acc = (r > 7) ? 4'd7 : 4'd8;
`endif
    e.z = (e.acc == 4'd0);
    return e;
  endfunction

  // Present a command just after a rising edge; return just after the accepting edge
  // with cmd_valid still high. last_rv holds res_valid in the accepting cycle.
  task automatic issue(input int u, input logic [1:0] o, input logic [3:0] d, input bit push);
    exp_t e;
    bit   ok;
    cv[u]  = 1'b1;
    op[u]  = o;
    dat[u] = d;
    ok     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy[u]) begin
        ok = 1'b1;
        last_rv = rv[u];
        break;
      end
    end
    if (!ok) check("issue_timeout", 16'(rdy[u]), 16'd1);
    if (push) begin
      e = model(m_acc[u], o, d);
      if (o == 2'b01 || o == 2'b10) begin
        m_a[u] = m_acc[u];
        m_b[u] = d;
        m_c[u] = (o == 2'b10);
      end
      m_acc[u] = e.acc;
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    check("drain_q0", 16'(q0.size()), 16'd0);
    check("drain_q1", 16'(q1.size()), 16'd0);
  endtask

  // Scoreboard consumer: every res_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rv[0]) begin
      if (q0.size() == 0) check("rv0_unexpected", 16'(rv[0]), 16'd0);
      else begin
        e = q0.pop_front();
        check("res0", {acc[0], fc[0], fz[0], fv[0]}, 16'(e));
      end
    end
    if (rv[1]) begin
      if (q1.size() == 0) check("rv1_unexpected", 16'(rv[1]), 16'd0);
      else begin
        e = q1.pop_front();
        check("res1", {acc[1], fc[1], fz[1], fv[1]}, 16'(e));
      end
    end
  end

  initial begin
    logic [3:0] ld_vals [4];
    ld_vals = '{4'd1, 4'd2, 4'd3, 4'd0};
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; cv[u] = 1'b0; op[u] = 2'b00; dat[u] = 4'd0;
      m_acc[u] = 4'd0; m_a[u] = 4'd0; m_b[u] = 4'd0; m_c[u] = 1'b0;
    end
    last_rv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Reset state held over three idle cycles: acc,c,z,v,ready,res_valid.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_idle0", {acc[0], fc[0], fz[0], fv[0], rdy[0], rv[0]}, 16'b0000_0_1_0_1_0);
      check("reset_idle1", {acc[1], fc[1], fz[1], fv[1], rdy[1], rv[1]}, 16'b0000_0_1_0_1_0);
    end
    check("reset_alu0", {aa[0], bb[0], ctl[0]}, 16'd0);
    @(posedge clk);
    #1;

    // LOAD 3 then ADD 4 presented in the LOAD's res_valid cycle.
    issue(0, 2'b00, 4'd3, 1'b1);
    issue(0, 2'b01, 4'd4, 1'b1);
    check("add_in_rv_cycle", 16'(last_rv), 16'd1);
    cv[0] = 1'b0;
    @(negedge clk);
    check("add_busy", {rdy[0], rv[0]}, 16'b00);
    @(negedge clk);
    check("add_done", {rdy[0], rv[0]}, 16'b11);
    check("add_alu", {aa[0], bb[0], ctl[0]}, {m_a[0], m_b[0], m_c[0]});
    @(posedge clk);
    #1;

    // Signed overflow and zero-result cases.
    issue(0, 2'b00, 4'd7, 1'b1);
    issue(0, 2'b01, 4'd1, 1'b1);
    issue(0, 2'b00, 4'd8, 1'b1);
    issue(0, 2'b10, 4'd1, 1'b1);
    issue(0, 2'b00, 4'd5, 1'b1);
    issue(0, 2'b10, 4'd5, 1'b1);
    cv[0] = 1'b0;
    drain();
    check("sub_zero", {acc[0], fc[0], fz[0], fv[0]}, 16'b0000_1_1_0);
    check("sub_alu", {aa[0], bb[0], ctl[0]}, {4'd5, 4'd5, 1'b1});
    @(posedge clk);
    #1;

    // Four back-to-back LOADs, then a CLR; adder operands must not move.
    for (int i = 0; i < 4; i++) begin
      issue(0, 2'b00, ld_vals[i], 1'b1);
      if (i > 0) check("b2b_rv", 16'(last_rv), 16'd1);
      check("b2b_alu", {aa[0], bb[0], ctl[0]}, {m_a[0], m_b[0], m_c[0]});
    end
    cv[0] = 1'b0;
    @(negedge clk);
    check("b2b_rv_last", 16'(rv[0]), 16'd1);
    check("b2b_final", {acc[0], fz[0]}, {4'd0, 1'b1});
    @(negedge clk);
    check("b2b_rv_end", 16'(rv[0]), 16'd0);
    @(posedge clk);
    #1;
    issue(0, 2'b00, 4'd9, 1'b1);
    issue(0, 2'b11, 4'd6, 1'b1);
    cv[0] = 1'b0;
    drain();
    @(posedge clk);
    #1;

    // SETTLE=4: ADD with cmd_valid held; busy for exactly 4 cycles, one accept.
    issue(1, 2'b00, 4'd2, 1'b1);
    issue(1, 2'b01, 4'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_busy", {rdy[1], rv[1]}, 16'b00);
    end
    @(posedge clk);
    #1;
    cv[1] = 1'b0;
    @(negedge clk);
    check("hold_done", {rdy[1], rv[1]}, 16'b11);
    check("hold_alu", {aa[1], bb[1], ctl[1]}, {4'd2, 4'd3, 1'b0});
    @(posedge clk);
    #1;

    // Reset in the second EXEC cycle aborts the ADD without a result pulse.
    issue(1, 2'b01, 4'd1, 1'b0);
    cv[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    m_acc[1] = 4'd0; m_a[1] = 4'd0; m_b[1] = 4'd0; m_c[1] = 1'b0;
    @(negedge clk);
    check("abort_out", {acc[1], fc[1], fz[1], fv[1], rdy[1], rv[1]}, 16'b0000_0_1_0_1_0);
    check("abort_alu", {aa[1], bb[1], ctl[1]}, 16'd0);
    repeat (6) @(negedge clk);
    check("abort_quiet", {acc[1], rv[1]}, 16'd0);
    @(posedge clk);
    #1;

    // Normal operation resumes after the abort.
    issue(1, 2'b01, 4'd6, 1'b1);
    issue(1, 2'b10, 4'd9, 1'b1);
    cv[1] = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_acc_seq.md
# alu_acc_seq

Sequential accumulator front-end for the 4-bit adder/subtractor (`AddSub4b`). It accepts LOAD/ADD/SUB/CLR commands over a valid/ready handshake and drives the adder's `A`, `B` and `Ctrl` inputs from registers. After a programmable settle time it captures `S` and `C0` back into a 4-bit accumulator and updates the carry, zero and overflow flags. It sits both upstream (operand/control source) and downstream (result sink) of the combinational adder.

## Interface
- `SETTLE`, default 1: adder settle time in cycles; legal range 1..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- `cmd_data` in 4: operand for LOAD/ADD/SUB; ignored for CLR.
- `alu_a` out 4: registered, to adder `A`.
- `alu_b` out 4: registered, to adder `B`.
- `alu_ctrl` out 1: registered, to adder `Ctrl` (0 add, 1 sub).
- `alu_s` in 4: from adder `S`.
- `alu_c0` in 1: from adder `C0`.
- `acc` out 4: accumulator.
- `flag_c` out 1: raw `C0` of last ADD/SUB (for SUB, 1 = no borrow).
- `flag_z` out 1: `acc` == 0.
- `flag_v` out 1: signed (two's-complement) overflow of last ADD/SUB.
- `res_valid` out 1: one-cycle pulse; `acc`/flags updated.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - EXEC: `cmd_ready`=0; settle counter runs.
- Accept = `cmd_valid && cmd_ready` at a rising edge. The command is accepted only in IDLE.
- LOAD accepted:
  - `acc` ← `cmd_data`.
  - `flag_c`=0, `flag_v`=0, `flag_z`=(`cmd_data`==0).
  - Stay in IDLE.
- CLR accepted:
  - `acc` ← 0.
  - `flag_c`=0, `flag_v`=0, `flag_z`=1.
  - Stay in IDLE.
- ADD/SUB accepted:
  - `alu_a` ← `acc`, `alu_b` ← `cmd_data`, `alu_ctrl` ← (op==SUB).
  - Counter ← 0; go to EXEC.
- EXEC:
  - Counter increments every cycle.
  - At the edge where counter == `SETTLE`-1: `acc` ← result, `flag_c` ← `alu_c0`, `flag_v` ← V, `flag_z` ← (result==0); go to IDLE.
- V:
  - ADD: `alu_a[3]`==`alu_b[3]` && `alu_s[3]`!=`alu_a[3]`.
  - SUB: `alu_a[3]`!=`alu_b[3]` && `alu_s[3]`!=`alu_a[3]`.
- Result is `alu_s` (modulo 16, wrap-around), subject to Configuration.
- `alu_a`, `alu_b`, `alu_ctrl` hold their values outside EXEC. They change only on ADD/SUB accept.
- Commands with `cmd_valid` high while `cmd_ready`=0 are not consumed. The source must hold them stable until accepted.
- `SETTLE` outside 1..15 is unsupported. The bench does not exercise it.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready`=1, `res_valid`=0.
  - `acc`=0, `flag_z`=1, `flag_c`=0, `flag_v`=0.
  - `alu_a`=0, `alu_b`=0, `alu_ctrl`=0, counter=0.
- `rst` mid-EXEC aborts the operation. No `res_valid` pulse; all registers take their reset values at that edge.
- `rst` has priority over any simultaneous command.
- LOAD/CLR latency and throughput:
  - Accepted at edge N; `acc`/flags new and `res_valid`=1 in the cycle after N.
  - Back-to-back LOAD/CLR at 1 per cycle.
- ADD/SUB latency:
  - Accepted at edge N; write at edge N+`SETTLE`.
  - `res_valid`=1 and `cmd_ready`=1 in the cycle after N+`SETTLE`.
  - Next accept earliest at edge N+`SETTLE`+1, so throughput is 1 per (`SETTLE`+1) cycles.
- `res_valid` is high for exactly one cycle per completed command, including consecutive pulses on back-to-back LOADs.
- A command accepted in the same cycle as a `res_valid` pulse is legal and follows the rules above.

## Configuration
- `ALU_ACC_SAT_EN` defined: saturating signed arithmetic.
  - On an ADD/SUB write with V=1, `acc` is clamped instead of taking `alu_s`.
  - Clamp to 4'b0111 if `alu_a[3]`=0, else 4'b1000.
  - `flag_v`=1 and `flag_c`=`alu_c0` regardless; `flag_z` is computed on the clamped value.
- Undefined: `acc` ← `alu_s` always (wrap-around). Flags are unchanged from the rules above.

## Test plan
- Reset, then idle 3 cycles -> `acc`=0, `flag_z`=1, `flag_c`=0, `flag_v`=0, `cmd_ready`=1, `res_valid`=0 throughout.
- `SETTLE`=1: LOAD 3, then ADD 4 presented in the `res_valid` cycle -> `acc`=7, C=0, V=0, Z=0. `res_valid` 2 cycles after ADD accept; `cmd_ready`=0 for exactly 1 cycle.
- LOAD 7, ADD 1 -> without macro: `acc`=8, V=1, C=0. With `ALU_ACC_SAT_EN`: `acc`=7, V=1.
- LOAD 8, SUB 1 -> without macro: `acc`=7, C=1, V=1. With macro: `acc`=8. Then LOAD 5, SUB 5 -> `acc`=0, Z=1, C=1, V=0.
- `SETTLE`=4: ADD with `cmd_valid` held high -> `cmd_ready`=0 for 4 cycles, one accept only. Assert `rst` in the 2nd EXEC cycle -> no `res_valid`, all outputs at reset values.
- Four back-to-back LOADs 1,2,3,0 -> `res_valid` high 4 consecutive cycles. Final `acc`=0, Z=1. `alu_a`/`alu_b`/`alu_ctrl` unchanged throughout.
